// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant and encoded index.
// Optional burst limit compiled in with `define RR_ARB_BURST_LIMIT_EN.
module rr_arbiter4 #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic [1:0] ptr
);

    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_BURST < 2 || MAX_BURST > 255 || (2 ** CNT_W) <= MAX_BURST) begin : g_bad_params
        $error("rr_arbiter4: MAX_BURST must be 2..255 and fit in CNT_W bits");
    end

    state_t     state, state_d;
    logic [3:0] gnt_d;
    logic [1:0] idx_d, ptr_d;
    logic       owner_req, rotate, new_grant;
    logic [3:0] cand;
    logic [2:0] pick_res;

    // Returns {found, index} of the first set bit of r searching p, p+1, p+2, p+3 (mod 4).
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] i;
        pick = '0;
        for (int k = 3; k >= 0; k--) begin
            i = p + 2'(k);
            if (r[i]) pick = {1'b1, i};
        end
    endfunction

`ifdef RR_ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             at_limit;
    logic [3:0]       others;
`endif

    // State register: every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state     <= state_d;
            gnt       <= gnt_d;
            gnt_idx   <= idx_d;
            gnt_valid <= |gnt_d;
            ptr       <= ptr_d;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt       <= cnt_d;
`endif
        end
    end

    // Next-state logic: decide whether this edge starts a new grant.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        owner_req = req[gnt_idx];
`ifdef RR_ARB_BURST_LIMIT_EN
        others    = req & ~(4'b0001 << gnt_idx);
        at_limit  = (cnt == CNT_W'(MAX_BURST - 1));
        rotate    = (state == GRANT) && owner_req && at_limit && (|others);
        cand      = rotate ? others : req;
`else
        rotate    = 1'b0;
        cand      = req;
`endif
        pick_res  = pick(cand, ptr);
        new_grant = 1'b0;
        state_d   = state;
        case (state)
            IDLE: begin
                new_grant = |req;
                if (|req) state_d = GRANT;
            end
            GRANT: begin
                new_grant = (!owner_req || rotate) && (|cand);
                if (!owner_req && !(|req)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: values loaded into the grant flops at this edge.
    always_comb begin
        gnt_d = gnt;
        idx_d = gnt_idx;
        ptr_d = ptr;
`ifdef RR_ARB_BURST_LIMIT_EN
        cnt_d = cnt;
`endif
        if (new_grant) begin
            gnt_d = 4'b0001 << pick_res[1:0];
            idx_d = pick_res[1:0];
            ptr_d = pick_res[1:0] + 2'd1;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt_d = '0;
`endif
        end else if (state_d == IDLE) begin
            gnt_d = '0;
        end else begin
`ifdef RR_ARB_BURST_LIMIT_EN
            // Owner keeps the grant; counter saturates at the limit.
            if (!at_limit) cnt_d = cnt + CNT_W'(1);
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized requests
// checked against a cycle-level round-robin reference model.
module tb_rr_arbiter4;

    localparam int MAX_BURST = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic [1:0] ptr;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter4 #(.MAX_BURST(MAX_BURST), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .ptr      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner, pointer and number of consecutive cycles held.
    bit m_valid;
    int m_owner, m_ptr, m_run;

    function automatic int m_pick(input logic [3:0] r, input int p, input int excl);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (p + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic void m_grant(input int s);
        m_valid = 1'b1;
        m_owner = s;
        m_ptr   = (s + 1) % 4;
        m_run   = 1;
    endfunction

    function automatic void m_reset();
        m_valid = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_run   = 0;
    endfunction

    function automatic void m_edge(input logic [3:0] r);
        bit limit_hit;
        limit_hit = 1'b0;
`ifdef RR_ARB_BURST_LIMIT_EN
        limit_hit = (m_run >= MAX_BURST) && ((r & ~(4'b0001 << m_owner)) != 4'b0);
`endif
        if (!m_valid) begin
            if (r != 4'b0) m_grant(m_pick(r, m_ptr, -1));
        end else if (r[m_owner]) begin
            if (limit_hit) m_grant(m_pick(r, m_ptr, m_owner));
            else m_run++;
        end else if (r != 4'b0) begin
            m_grant(m_pick(r, m_ptr, -1));
        end else begin
            m_valid = 1'b0;
        end
    endfunction

    function automatic logic [8:0] m_expect();
        logic [3:0] g;
        g = m_valid ? (4'b0001 << m_owner) : 4'b0000;
        return {g, 2'(m_owner), m_valid, 2'(m_ptr)};
    endfunction

    function automatic logic [8:0] observed();
        return {gnt, gnt_idx, gnt_valid, ptr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        req   = 4'b1111;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = observed();
        n_tests++;
        if (obs !== 9'b0000_00_0_00) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", obs, 9'b0000_00_0_00);
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            obs = observed();
            n_tests++;
            if (obs !== 9'b0001_00_1_01) begin
                n_fail++;
                $display("FAIL reset_first_grant cyc=%0d got=%b exp=%b", c, obs, 9'b0001_00_1_01);
            end
        end
    endtask

    task automatic test_switch();
        logic [8:0] obs;
        req = 4'b0000;
        apply_reset();
        req = 4'b1010;
        step();
        obs = observed();
        n_tests++;
        if (obs !== 9'b0010_01_1_10) begin
            n_fail++;
            $display("FAIL switch_first got=%b exp=%b", obs, 9'b0010_01_1_10);
        end
        req = 4'b1000;
        step();
        obs = observed();
        n_tests++;
        if (obs !== 9'b1000_11_1_00) begin
            n_fail++;
            $display("FAIL switch_no_bubble got=%b exp=%b", obs, 9'b1000_11_1_00);
        end
    endtask

    task automatic test_pulse();
        logic [8:0] obs;
        req = 4'b0000;
        apply_reset();
        req = 4'b0100;
        step();
        obs = observed();
        n_tests++;
        if (obs !== 9'b0100_10_1_11) begin
            n_fail++;
            $display("FAIL pulse_grant got=%b exp=%b", obs, 9'b0100_10_1_11);
        end
        req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = observed();
            n_tests++;
            if (obs !== 9'b0000_10_0_11) begin
                n_fail++;
                $display("FAIL pulse_idle cyc=%0d got=%b exp=%b", c, obs, 9'b0000_10_0_11);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] obs;
        req = 4'b0000;
        apply_reset();
        req = 4'b0100;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        obs = observed();
        n_tests++;
        if (obs !== 9'b0000_00_0_00) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=%b", obs, 9'b0000_00_0_00);
        end
        req = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_burst();
        logic [3:0] exp_g;
        req = 4'b0000;
        apply_reset();
        req = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            step();
`ifdef RR_ARB_BURST_LIMIT_EN
            exp_g = ((c / MAX_BURST) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
            exp_g = 4'b0001;
`endif
            n_tests++;
            if (gnt !== exp_g) begin
                n_fail++;
                $display("FAIL burst cyc=%0d gnt=%b exp=%b", c, gnt, exp_g);
            end
        end
    endtask

    task automatic test_solo_hold();
        req = 4'b0000;
        apply_reset();
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            n_tests++;
            if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL solo_hold cyc=%0d gnt=%b valid=%b exp=0001/1", c, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] obs, exp_v;
        req = 4'b0000;
        apply_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            m_edge(req);
            step();
            obs   = observed();
            exp_v = m_expect();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc=%0d req=%b got=%b exp=%b", c, req, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_switch();
        test_pulse();
        test_async_reset();
        test_burst();
        test_solo_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (such as a shared bus or datapath slot) between requesters Y0..Y3.
- Produces a registered one-hot grant and its 2-bit encoded index, which follows the same encoding as the team's 4-to-2 encoder (Y3/Y2 set bit 1, Y3/Y1 set bit 0).
- Sits between the requesting blocks and the shared resource's select input.
- The grant is held while the owner keeps requesting. An optional burst limit forces rotation.

Parameters:
- MAX_BURST, 4, maximum consecutive grant cycles per owner when the burst limit is compiled in. Legal range 2..255.
- CNT_W, 8, width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i is requester Yi. Level-sensitive.
- gnt  output  4  one-hot grant, registered. All zero when idle.
- gnt_idx  output  2  encoded index of the granted requester. Holds its last value when idle.
- gnt_valid  output  1  high when any gnt bit is high.
- ptr  output  2  current round-robin priority pointer (debug/observability).

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_idx=0, gnt_valid=0, ptr=0.
  - State=IDLE, burst counter=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- Priority order: starting at ptr, search ptr, ptr+1, ptr+2, ptr+3, with the index wrapping mod 4.
- IDLE:
  - If req != 0 at a clock edge, select the first set bit in priority order.
  - Next cycle: gnt = onehot(sel), gnt_idx = sel, gnt_valid=1, cnt=0, state=GRANT.
  - Latency is 1 cycle from req to gnt.
  - If req == 0, stay in IDLE.
- GRANT, with owner = gnt_idx, evaluated at each clock edge:
  - req[owner]=1 and no forced rotation: keep the grant; cnt increments (saturating at MAX_BURST-1).
  - req[owner]=0, with other requests pending: switch the grant directly to the next requester in priority order in the same edge. There is no idle bubble.
  - req[owner]=0, with no requests pending: gnt=0, gnt_valid=0, state=IDLE.
- Pointer update: on every new grant to sel, ptr becomes sel+1 mod 4. The previous owner therefore has the lowest priority on the next arbitration.
- Simultaneous events:
  - Owner drop and new requests in the same cycle are resolved in that single edge.
  - Requests arriving during a grant only wait; they are never lost while held high.
- Requesters must hold req until granted. Deasserting req before the grant is legal; that requester is simply not served.
- gnt is always one-hot or zero. gnt_idx always equals the encoding of gnt whenever gnt_valid=1.
- Glitch-free: all outputs come directly from flops.

Optional Feature:
- Macro: RR_ARB_BURST_LIMIT_EN.
- Defined:
  - When cnt == MAX_BURST-1 and req[owner]=1 and any other req bit is set, the grant rotates at that edge to the next requester in priority order.
  - The forced-off owner re-enters arbitration at the lowest priority.
  - If no other requester is pending, the owner keeps the grant and cnt holds at MAX_BURST-1.
- Not defined: the burst counter is not instantiated. The owner holds the grant for as long as req[owner]=1, which permits unbounded hold.

Test Plan:
- Reset with req=4'b1111, then release rst_n → first edge: gnt=0001, gnt_idx=0, ptr=1; owner 0 holds while req[0]=1.
- req=1010 from IDLE with ptr=0 → gnt=0010, idx=1. Drop req[1] → next edge gnt=1000, idx=3, ptr=0, no idle cycle.
- req[2] pulsed alone for 1 cycle then dropped → gnt=0100 for exactly 1 cycle, then gnt=0, gnt_valid=0, state IDLE.
- rst_n asserted low mid-cycle while gnt=0100 → gnt=0, gnt_valid=0, ptr=0 immediately, before the next clk edge.
- With RR_ARB_BURST_LIMIT_EN and MAX_BURST=4, req=0011 held constant → gnt alternates 0001 ×4 cycles, 0010 ×4 cycles, repeating. Without the macro → gnt=0001 indefinitely.
- req=0001 only, with the macro defined, held for 10 cycles → gnt stays 0001 for all 10 cycles; cnt saturates at 3.
